// File: rtl/dmem_pkg.sv
// Shared definitions for the RV32I data memory controller: access sizes and FSM states.
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    function automatic logic size_illegal(input logic [2:0] size);
        return (size == 3'b011) || (size == 3'b110) || (size == 3'b111);
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response handshake bundle between the core memory stage (master) and dmem_ctrl (slave).
interface dmem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_size;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_fault;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I loads/stores: byte enables, write-data replication, load extension.
// DMEM_MISALIGN_FAULT_EN: when defined, misaligned H/W accesses raise misalign; otherwise they are silently aligned.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Write data is replicated across lanes; the byte enables pick which copy lands.
    always_comb begin
        be        = '0;
        wdata_sh  = '0;
        rdata_ext = '0;
        byte_sel  = rword[8*lane +: 8];
        half_sel  = lane[1] ? rword[31:16] : rword[15:0];
        case (size)
            SZ_B, SZ_BU: begin
                be       = 4'b0001 << lane;
                wdata_sh = {4{wdata[7:0]}};
                if (size == SZ_B) rdata_ext = {{24{byte_sel[7]}}, byte_sel};
                else              rdata_ext = {24'd0, byte_sel};
            end
            SZ_H, SZ_HU: begin
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wdata_sh = {2{wdata[15:0]}};
                if (size == SZ_H) rdata_ext = {{16{half_sel[15]}}, half_sel};
                else              rdata_ext = {16'd0, half_sel};
            end
            SZ_W: begin
                be        = 4'b1111;
                wdata_sh  = wdata;
                rdata_ext = rword;
            end
            default: begin
                be = '0;
            end
        endcase
    end

`ifdef DMEM_MISALIGN_FAULT_EN
    assign misalign = (((size == SZ_H) || (size == SZ_HU)) && lane[0])
                    || ((size == SZ_W) && (lane != 2'b00));
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// RV32I data memory with valid/ready handshake, configurable wait states and access-fault reporting.
// Misaligned-access faulting is selected by DMEM_MISALIGN_FAULT_EN (see dmem_lane_align).
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  bus,
    output logic        busy
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        size_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              fault_q;

    logic [31:0]       mem [DEPTH_WORDS] = '{default: '0};

    logic [IDX_W-1:0]  idx;
    logic [31:0]       rword;
    logic              out_of_range;
    logic              fault;
    logic [3:0]        be;
    logic [31:0]       wdata_sh;
    logic [31:0]       rdata_ext;
    logic              misalign;

    assign idx   = addr_q[IDX_W+1:2];
    assign rword = mem[idx];

    // Any set address bit above the array index is out of range; upper bits must not alias.
    generate
        if (ADDR_W - 2 > IDX_W) begin : g_range
            assign out_of_range = |addr_q[ADDR_W-1:IDX_W+2];
        end else begin : g_no_range
            assign out_of_range = 1'b0;
        end
    endgenerate

    dmem_lane_align u_align (
        .size      (size_q),
        .lane      (addr_q[1:0]),
        .wdata     (wdata_q),
        .rword     (rword),
        .be        (be),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext),
        .misalign  (misalign)
    );

    assign fault = size_illegal(size_q)
                 || (we_q && size_q[2])
                 || out_of_range
                 || misalign;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        busy          = 1'b1;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                busy          = 1'b0;
                if (bus.req_valid) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && bus.req_valid) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                size_q  <= bus.req_size;
                wdata_q <= bus.req_wdata;
            end
            if (state_q == ACCESS) begin
                rdata_q <= (fault || we_q) ? 32'd0 : rdata_ext;
                fault_q <= fault;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == ACCESS && we_q && !fault) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_fault = fault_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed, table-driven bench for dmem_ctrl with WAIT_CYCLES=2 and 256 words.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int WC    = 2;
    localparam int DEPTH = 256;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    dmem_ctrl_if #(.ADDR_W(32)) bus ();

    dmem_ctrl #(
        .ADDR_W      (32),
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic we, input logic [31:0] addr, input logic [2:0] size,
                                input logic [31:0] wdata, input logic [31:0] er, input logic ef);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.wdata = wdata;
        v.exp_rdata = er; v.exp_fault = ef;
        vecs.push_back(v);
    endfunction

    // Issue one request; returns the response and the edges from accept to rsp_valid.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic hold,
                        output logic [31:0] rdata, output logic fault, output int lat);
        @(negedge clk);
        check("req_ready before issue", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_size  = size;
        bus.req_wdata = wdata;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        rdata = bus.rsp_rdata;
        fault = bus.rsp_fault;
        if (!hold) begin
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1 bus.rsp_ready = 1'b0;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        ft;
        int          lat;

        add(1, 32'h10, SZ_W,  32'hDEADBEEF, 32'h0,        0);
        add(0, 32'h10, SZ_W,  32'h0,        32'hDEADBEEF, 0);
        add(1, 32'h13, SZ_B,  32'h00000080, 32'h0,        0);
        add(0, 32'h13, SZ_B,  32'h0,        32'hFFFFFF80, 0);
        add(0, 32'h13, SZ_BU, 32'h0,        32'h00000080, 0);
        add(0, 32'h10, SZ_W,  32'h0,        32'h80ADBEEF, 0);
        add(1, 32'h22, SZ_H,  32'h00001234, 32'h0,        0);
        add(0, 32'h22, SZ_HU, 32'h0,        32'h00001234, 0);
        add(0, 32'h20, SZ_W,  32'h0,        32'h12340000, 0);
        add(1, 32'h22, SZ_H,  32'h00008001, 32'h0,        0);
        add(0, 32'h22, SZ_H,  32'h0,        32'hFFFF8001, 0);
        add(0, 32'h22, SZ_B,  32'h0,        32'h00000001, 0);
        add(0, 32'h12, SZ_HU, 32'h0,        32'h000080AD, 0);
        add(0, 32'h12, SZ_H,  32'h0,        32'hFFFF80AD, 0);
        add(1, 32'h3FC, SZ_W, 32'h0BADF00D, 32'h0,        0);
        add(0, 32'h3FC, SZ_W, 32'h0,        32'h0BADF00D, 0);
        add(1, DEPTH*4, SZ_W, 32'h55555555, 32'h0,        1);
        add(1, 32'h10, 3'b011, 32'h66666666, 32'h0,       1);
        add(1, 32'h10, SZ_BU, 32'h77777777, 32'h0,        1);
        add(1, 32'h80000010, SZ_W, 32'h88888888, 32'h0,   1);
        add(0, DEPTH*4, SZ_W, 32'h0,        32'h0,        1);
        add(0, 32'h10, 3'b110, 32'h0,       32'h0,        1);
        add(0, 32'h10, SZ_W,  32'h0,        32'h80ADBEEF, 0);
        add(0, 32'h00, SZ_W,  32'h0,        32'h00000000, 0);
        add(0, 32'h20, SZ_W,  32'h0,        32'h80010000, 0);
`ifdef DMEM_MISALIGN_FAULT_EN
        add(0, 32'h12, SZ_W,  32'h0,        32'h0,        1);
        add(0, 32'h13, SZ_H,  32'h0,        32'h0,        1);
        add(1, 32'h11, SZ_W,  32'hAAAAAAAA, 32'h0,        1);
`else
        add(0, 32'h12, SZ_W,  32'h0,        32'h80ADBEEF, 0);
        add(0, 32'h13, SZ_H,  32'h0,        32'hFFFF80AD, 0);
        add(0, 32'h11, SZ_HU, 32'h0,        32'h0000BEEF, 0);
`endif
        add(0, 32'h10, SZ_W,  32'h0,        32'h80ADBEEF, 0);

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_size  = SZ_W;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset rsp_fault", 32'(bus.rsp_fault), 32'd0);
        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);

        foreach (vecs[i]) begin
            xact(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata, 1'b0, rd, ft, lat);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d fault", i), 32'(ft), 32'(vecs[i].exp_fault));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(WC + 1));
        end

        // Backpressure: response held for 5 cycles while a stray request is presented.
        xact(1'b0, 32'h10, SZ_W, 32'h0, 1'b1, rd, ft, lat);
        check("bp first rdata", rd, 32'h80ADBEEF);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h0;
        bus.req_size  = SZ_W;
        bus.req_wdata = 32'hFFFFFFFF;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("bp%0d rsp_rdata", k), bus.rsp_rdata, 32'h80ADBEEF);
            check($sformatf("bp%0d req_ready", k), 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        check("bp release rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("bp release req_ready", 32'(bus.req_ready), 32'd1);
        xact(1'b0, 32'h0, SZ_W, 32'h0, 1'b0, rd, ft, lat);
        check("bp stray ignored", rd, 32'h0);

        // Reset while the store is still waiting: the write must be abandoned.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h30;
        bus.req_size  = SZ_W;
        bus.req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        check("rst-wait busy before", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst-wait rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst-wait busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        xact(1'b0, 32'h30, SZ_W, 32'h0, 1'b0, rd, ft, lat);
        check("rst-wait no write", rd, 32'h0);

        // Reset while a store response is held: the write already happened and persists.
        xact(1'b1, 32'h34, SZ_W, 32'h11223344, 1'b1, rd, ft, lat);
        check("rst-resp rsp_valid before", 32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst-resp rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst-resp rsp_fault", 32'(bus.rsp_fault), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        xact(1'b0, 32'h34, SZ_W, 32'h0, 1'b0, rd, ft, lat);
        check("rst-resp write kept", rd, 32'h11223344);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
